data_reg_queue: RTL and testbench



---
 rtl/data_reg_queue.sv | 103 ++++++++++
 tb/tb_data_reg_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_reg_queue.sv
// rtl/data_reg_queue.sv - DEPTH-entry first-word-fall-through register queue with valid/ready handshakes
//
// Purpose: absorbs short rate mismatches between a sample producer and the
// downstream datapath. The head word is presented combinationally from
// storage (FWFT). A word pushed into an empty queue is visible after the
// push edge. There is no same-cycle bypass from input to output.
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-high reset
//   flush       synchronous clear of pointers/occupancy (overrides push/pop)
//   in_data     write data
//   in_valid    producer has a word
//   in_ready    queue can accept a word (count != DEPTH)
//   out_data    head-of-queue word
//   out_valid   out_data is valid (count != 0)
//   out_ready   consumer takes the head word
//   count       current occupancy
//   almost_full count >= AFULL
//   max_count   highest occupancy since reset (flush does not clear it)

module data_reg_queue #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4,
    parameter int AFULL = 3,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic [CW-1:0]    max_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready    = (count != CW'(DEPTH));
    assign out_valid   = (count != '0);
    assign almost_full = (count >= CW'(AFULL));
    assign out_data    = mem[rd_ptr];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            max_count <= '0;
        end else if (flush) begin
            // Storage is left as-is; out_valid=0 hides the stale words.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_nxt;
            // count_nxt never exceeds DEPTH, so the watermark saturates there.
            if (count_nxt > max_count) begin
                max_count <= count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_data_reg_queue.sv
// tb/tb_data_reg_queue.sv - self-checking bench for data_reg_queue

module tb_data_reg_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [13:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        almost_full;
    logic [2:0]  max_count;

    logic        flush3;
    logic [13:0] in_data3;
    logic        in_valid3;
    logic        in_ready3;
    logic [13:0] out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  count3;
    logic        almost_full3;
    logic [1:0]  max_count3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_reg_queue #(.WIDTH(14), .DEPTH(4), .AFULL(3)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .almost_full(almost_full), .max_count(max_count)
    );

    data_reg_queue #(.WIDTH(14), .DEPTH(3), .AFULL(2)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .count(count3), .almost_full(almost_full3), .max_count(max_count3)
    );

    typedef struct {
        logic        f;
        logic        iv;
        logic [13:0] d;
        logic        ordy;
        int          c;
        logic        ov;
        logic [13:0] od;
        logic        ir;
        logic        af;
        int          mx;
    } vec_t;

    vec_t tbl [15];

    // Reference model: a plain queue plus a running maximum.
    int q[$];
    int mmax;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic f, input logic iv, input logic [13:0] d, input logic ordy);
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " count"}, int'(count), 0);
        chk({tag, " out_valid"}, int'(out_valid), 0);
        chk({tag, " in_ready"}, int'(in_ready), 1);
        chk({tag, " out_data"}, int'(out_data), 0);
        chk({tag, " almost_full"}, int'(almost_full), 0);
        chk({tag, " max_count"}, int'(max_count), 0);
    endtask

    task automatic model_edge(input logic f, input logic iv, input int d, input logic ordy);
        if (f) begin
            q.delete();
        end else begin
            bit do_push;
            bit do_pop;
            do_push = iv && (q.size() < DEPTH);
            do_pop  = ordy && (q.size() > 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        if (q.size() > mmax) mmax = q.size();
    endtask

    task automatic check_model(input string tag);
        chk({tag, " count"}, int'(count), q.size());
        chk({tag, " out_valid"}, int'(out_valid), int'(q.size() != 0));
        chk({tag, " in_ready"}, int'(in_ready), int'(q.size() != DEPTH));
        chk({tag, " almost_full"}, int'(almost_full), int'(q.size() >= 3));
        chk({tag, " max_count"}, int'(max_count), mmax);
        if (q.size() != 0) chk({tag, " out_data"}, int'(out_data), q[0]);
    endtask

    initial begin
        //            f  iv  d         ordy c  ov od        ir af mx
        tbl[0]  = '{1'b0, 1'b1, 14'h0001, 1'b0, 1, 1'b1, 14'h0001, 1'b1, 1'b0, 1};
        tbl[1]  = '{1'b0, 1'b1, 14'h0002, 1'b0, 2, 1'b1, 14'h0001, 1'b1, 1'b0, 2};
        tbl[2]  = '{1'b0, 1'b1, 14'h0003, 1'b0, 3, 1'b1, 14'h0001, 1'b1, 1'b1, 3};
        tbl[3]  = '{1'b0, 1'b1, 14'h0004, 1'b0, 4, 1'b1, 14'h0001, 1'b0, 1'b1, 4};
        tbl[4]  = '{1'b0, 1'b1, 14'h3FFF, 1'b1, 3, 1'b1, 14'h0002, 1'b1, 1'b1, 4};
        tbl[5]  = '{1'b0, 1'b1, 14'h3FFF, 1'b0, 4, 1'b1, 14'h0002, 1'b0, 1'b1, 4};
        tbl[6]  = '{1'b0, 1'b0, 14'h0000, 1'b1, 3, 1'b1, 14'h0003, 1'b1, 1'b1, 4};
        tbl[7]  = '{1'b0, 1'b0, 14'h0000, 1'b1, 2, 1'b1, 14'h0004, 1'b1, 1'b0, 4};
        tbl[8]  = '{1'b0, 1'b0, 14'h0000, 1'b1, 1, 1'b1, 14'h3FFF, 1'b1, 1'b0, 4};
        tbl[9]  = '{1'b0, 1'b0, 14'h0000, 1'b1, 0, 1'b0, 14'h0000, 1'b1, 1'b0, 4};
        tbl[10] = '{1'b0, 1'b1, 14'h0021, 1'b1, 1, 1'b1, 14'h0021, 1'b1, 1'b0, 4};
        tbl[11] = '{1'b0, 1'b1, 14'h0022, 1'b0, 2, 1'b1, 14'h0021, 1'b1, 1'b0, 4};
        tbl[12] = '{1'b1, 1'b1, 14'h0099, 1'b1, 0, 1'b0, 14'h0000, 1'b1, 1'b0, 4};
        tbl[13] = '{1'b0, 1'b1, 14'h0055, 1'b0, 1, 1'b1, 14'h0055, 1'b1, 1'b0, 4};
        tbl[14] = '{1'b0, 1'b0, 14'h0000, 1'b1, 0, 1'b0, 14'h0000, 1'b1, 1'b0, 4};

        rst = 1'b0;
        drv(1'b0, 1'b0, 14'h0, 1'b0);
        flush3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;

        // Reset asserted between edges must act without a clock edge.
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // Fill, full with simultaneous push/pop, drain, empty push, flush priority.
        for (int i = 0; i < 15; i++) begin
            drv(tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            @(negedge clk);
            chk($sformatf("vec%0d count", i), int'(count), tbl[i].c);
            chk($sformatf("vec%0d out_valid", i), int'(out_valid), int'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("vec%0d out_data", i), int'(out_data), int'(tbl[i].od));
            chk($sformatf("vec%0d in_ready", i), int'(in_ready), int'(tbl[i].ir));
            chk($sformatf("vec%0d almost_full", i), int'(almost_full), int'(tbl[i].af));
            chk($sformatf("vec%0d max_count", i), int'(max_count), tbl[i].mx);
        end

        // Reset mid-operation with traffic on both sides.
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b1, 14'(16'h0100 + i), 1'b0);
            @(negedge clk);
        end
        chk("pre-reset count", int'(count), 3);
        drv(1'b0, 1'b1, 14'h0200, 1'b1);
        @(posedge clk);
        drv(1'b0, 1'b1, 14'h0201, 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midop reset");
        @(negedge clk) rst = 1'b0;
        drv(1'b0, 1'b1, 14'h0077, 1'b0);
        @(negedge clk);
        chk("post-reset count", int'(count), 1);
        chk("post-reset out_data", int'(out_data), 14'h0077);
        drv(1'b0, 1'b0, 14'h0, 1'b0);

        // Pointer wrap on the DEPTH=3 instance, occupancy swinging 1..2.
        begin
            int sent = 0;
            int got = 0;
            int c3 = 0;
            for (int cyc = 0; cyc < 40 && got < 7; cyc++) begin
                if (c3 == 2 || sent == 7) begin
                    in_valid3 = 1'b0; out_ready3 = 1'b1;
                    chk("wrap out_valid", int'(out_valid3), 1);
                    chk("wrap out_data", int'(out_data3), 'h0A + got);
                    got++; c3--;
                end else begin
                    in_valid3 = 1'b1; out_ready3 = 1'b0;
                    in_data3 = 14'('h0A + sent);
                    sent++; c3++;
                end
                @(negedge clk);
                chk("wrap count", int'(count3), c3);
            end
            in_valid3 = 1'b0; out_ready3 = 1'b0;
            chk("wrap words delivered", got, 7);
            chk("wrap max_count", int'(max_count3), 2);
        end

        // Randomized traffic against the queue model.
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        q.delete();
        mmax = 0;
        for (int n = 0; n < 500; n++) begin
            logic f, iv, ordy;
            logic [13:0] d;
            check_model($sformatf("rand%0d", n));
            f    = ($urandom_range(0, 19) == 0);
            iv   = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            d    = 14'($urandom);
            drv(f, iv, d, ordy);
            @(negedge clk);
            model_edge(f, iv, int'(d), ordy);
        end
        check_model("rand end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
